// File: rtl/rand_sched_if.sv
// rand_sched_if: requester-side bundle for the shared random scheduler.
// Carries the LFSR input, requests, per-requester limits and results.
interface rand_sched_if #(
   parameter int N_REQ = 4
) ();
   logic [9:0]          rnd;
   logic [N_REQ-1:0]    req;
   logic [10*N_REQ-1:0] limit;
   logic [N_REQ-1:0]    ack;
   logic [9:0]          value;
   logic                busy;

   modport master (
      output rnd, req, limit,
      input  ack, value, busy
   );

   modport slave (
      input  rnd, req, limit,
      output ack, value, busy
   );
endinterface

// File: rtl/rand_sched.sv
// rand_sched: round-robin sharing of one LFSR among N_REQ requesters,
// with a draw gap and a 10-step restoring reduction into 0..limit.
module rand_sched #(
   parameter int N_REQ = 4,
   parameter int GAP   = 10
) (
   input logic         clk_22,
   input logic         rst,
   rand_sched_if.slave bus
);
   localparam int PW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    g_q, g_d;
   logic [5:0]       gcnt_q, gcnt_d;
   logic [9:0]       sample_q, sample_d;
   logic [10:0]      div_q, div_d;
   logic [9:0]       rem_q, rem_d;
   logic [3:0]       bitcnt_q, bitcnt_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [9:0]       value_q, value_d;

   logic [5:0]       gcnt_inc;
   logic             found;
   logic [PW-1:0]    win;
   logic [PW:0]      sum;
   logic [PW-1:0]    idx;
   logic [10:0]      t;
   logic [10:0]      diff;

   always_ff @(posedge clk_22 or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         g_q      <= '0;
         gcnt_q   <= '0;
         sample_q <= '0;
         div_q    <= '0;
         rem_q    <= '0;
         bitcnt_q <= '0;
         ack_q    <= '0;
         value_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         g_q      <= g_d;
         gcnt_q   <= gcnt_d;
         sample_q <= sample_d;
         div_q    <= div_d;
         rem_q    <= rem_d;
         bitcnt_q <= bitcnt_d;
         ack_q    <= ack_d;
         value_q  <= value_d;
      end
   end

   // Round-robin search starting at ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(N_REQ))
            sum = sum - (PW+1)'(N_REQ);
         idx = sum[PW-1:0];
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      gcnt_inc = (gcnt_q == 6'd63) ? gcnt_q : gcnt_q + 6'd1;
      t        = {rem_q, sample_q[bitcnt_q]};
      diff     = t - div_q;

      state_d  = state_q;
      ptr_d    = ptr_q;
      g_d      = g_q;
      gcnt_d   = gcnt_inc;
      sample_d = sample_q;
      div_d    = div_q;
      rem_d    = rem_q;
      bitcnt_d = bitcnt_q;
      ack_d    = '0;
      value_d  = value_q;

      unique case (state_q)
         IDLE: begin
            // gcnt_inc is the count as seen at this edge
            if (found && gcnt_inc >= 6'(GAP)) begin
               state_d  = DIV;
               g_d      = win;
               sample_d = bus.rnd;
               div_d    = 11'(bus.limit[int'(win)*10 +: 10]) + 11'd1;
               gcnt_d   = '0;
               rem_d    = '0;
               bitcnt_d = 4'd9;
            end
         end
         DIV: begin
            rem_d    = (t >= div_q) ? diff[9:0] : t[9:0];
            bitcnt_d = bitcnt_q - 4'd1;
            if (bitcnt_q == 4'd0)
               state_d = DONE;
         end
         DONE: begin
            value_d      = rem_q;
            ack_d[g_q]   = 1'b1;
            ptr_d        = (g_q == PW'(N_REQ-1)) ? '0 : g_q + PW'(1);
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ack   = ack_q;
   assign bus.value = value_q;
   assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_rand_sched.sv
// tb_rand_sched: directed checks of draw timing, reduction, arbitration,
// gap throughput, committed grants and asynchronous abort.
module tb_rand_sched;
   logic clk_22 = 1'b0;
   logic rst    = 1'b0;
   int   pass_cnt = 0;
   int   total    = 0;

   always #5 clk_22 = ~clk_22;

   rand_sched_if #(.N_REQ(4)) if0 ();
   rand_sched_if #(.N_REQ(4)) if1 ();

   rand_sched #(.N_REQ(4), .GAP(10)) dut0 (
      .clk_22 (clk_22),
      .rst    (rst),
      .bus    (if0)
   );

   rand_sched #(.N_REQ(4), .GAP(20)) dut1 (
      .clk_22 (clk_22),
      .rst    (rst),
      .bus    (if1)
   );

   task automatic step();
      @(posedge clk_22);
      #1;
   endtask

   task automatic release_rst();
      @(negedge clk_22);
      rst = 1'b1;
   endtask

   task automatic wait_ack0(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         n++;
         if (if0.ack != 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ack1(output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         n++;
         if (if1.ack != 4'b0000) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      if0.rnd = '0; if0.req = '0; if0.limit = '0;
      if1.rnd = '0; if1.req = '0; if1.limit = '0;
      rst = 1'b0;
      step();
      total++;
      if ({if0.ack, if0.value, if0.busy} !== 15'd0)
         $display("FAIL reset_dut0 got %0h want 0",
                  {if0.ack, if0.value, if0.busy});
      else pass_cnt++;
      total++;
      if ({if1.ack, if1.value, if1.busy} !== 15'd0)
         $display("FAIL reset_dut1 got %0h want 0",
                  {if1.ack, if1.value, if1.busy});
      else pass_cnt++;
   endtask

   task automatic test_first_draw();
      int busy_cnt;
      busy_cnt = 0;
      if0.rnd = 10'd523;
      if0.req = 4'b0001;
      if0.limit[9:0] = 10'd99;
      release_rst();
      for (int e = 1; e <= 22; e++) begin
         step();
         if (if0.busy) busy_cnt++;
         if (e == 9) begin
            total++;
            if (if0.busy !== 1'b0)
               $display("FAIL busy_e9 got %b want 0", if0.busy);
            else pass_cnt++;
         end
         if (e == 10) begin
            total++;
            if (if0.busy !== 1'b1)
               $display("FAIL busy_e10 got %b want 1", if0.busy);
            else pass_cnt++;
         end
         if (e == 20) begin
            total++;
            if (if0.ack !== 4'b0000)
               $display("FAIL ack_e20 got %b want 0000", if0.ack);
            else pass_cnt++;
         end
         if (e == 21) begin
            total++;
            if (if0.ack !== 4'b0001)
               $display("FAIL ack_e21 got %b want 0001", if0.ack);
            else pass_cnt++;
            total++;
            if (if0.value !== 10'd23)
               $display("FAIL value_523_99 got %0d want 23", if0.value);
            else pass_cnt++;
            if0.req = 4'b0000;
         end
         if (e == 22) begin
            total++;
            if (if0.ack !== 4'b0000)
               $display("FAIL ack_width got %b want 0000", if0.ack);
            else pass_cnt++;
            total++;
            if (if0.value !== 10'd23)
               $display("FAIL value_hold got %0d want 23", if0.value);
            else pass_cnt++;
         end
      end
      total++;
      if (busy_cnt != 11)
         $display("FAIL busy_cycles got %0d want 11", busy_cnt);
      else pass_cnt++;
   endtask

   task automatic test_limits();
      logic [9:0] lims [4] = '{10'd1023, 10'd0, 10'd776, 10'd777};
      logic [9:0] exps [4] = '{10'd777, 10'd0, 10'd0, 10'd777};
      bit ok;
      int n;
      for (int i = 0; i < 4; i++) begin
         if0.rnd = 10'd777;
         if0.limit[9:0] = lims[i];
         if0.req = 4'b0001;
         wait_ack0(ok, n);
         if0.req = 4'b0000;
         total++;
         if (!ok || if0.ack !== 4'b0001)
            $display("FAIL limit_ack[%0d] got %b want 0001", i, if0.ack);
         else pass_cnt++;
         total++;
         if (if0.value !== exps[i])
            $display("FAIL limit_value[%0d] got %0d want %0d",
                     i, if0.value, exps[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] seq [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0100, 4'b1000, 4'b0001,
                              4'b0100};
      bit ok;
      int n;
      rst = 1'b0;
      step();
      if0.limit = {4{10'd1023}};
      if0.rnd   = 10'd5;
      if0.req   = 4'b1111;
      release_rst();
      for (int i = 0; i < 9; i++) begin
         wait_ack0(ok, n);
         total++;
         if (!ok || if0.ack !== seq[i])
            $display("FAIL rr_order[%0d] got %b want %b", i, if0.ack, seq[i]);
         else pass_cnt++;
         total++;
         if (n != ((i == 0) ? 21 : 12))
            $display("FAIL rr_spacing[%0d] got %0d want %0d",
                     i, n, (i == 0) ? 21 : 12);
         else pass_cnt++;
         if (i == 4) if0.req = 4'b1101;
      end
      if0.req = 4'b0000;
   endtask

   task automatic test_gap20();
      bit ok;
      int n;
      rst = 1'b0;
      step();
      if1.req = 4'b0100;
      if1.limit[29:20] = 10'd1023;
      if1.rnd = 10'd100;
      release_rst();
      for (int i = 0; i < 3; i++) begin
         wait_ack1(ok, n);
         total++;
         if (!ok || if1.ack !== 4'b0100)
            $display("FAIL gap20_ack[%0d] got %b want 0100", i, if1.ack);
         else pass_cnt++;
         total++;
         if (n != ((i == 0) ? 31 : 20))
            $display("FAIL gap20_spacing[%0d] got %0d want %0d",
                     i, n, (i == 0) ? 31 : 20);
         else pass_cnt++;
      end
      total++;
      if (if1.value !== 10'd100)
         $display("FAIL gap20_value got %0d want 100", if1.value);
      else pass_cnt++;
      if1.req = 4'b0000;
   endtask

   task automatic test_commit();
      rst = 1'b0;
      step();
      if0.req = 4'b0100;
      if0.limit[29:20] = 10'd7;
      if0.rnd = 10'd300;
      release_rst();
      repeat (10) step();
      total++;
      if (if0.busy !== 1'b1)
         $display("FAIL commit_latch got %b want 1", if0.busy);
      else pass_cnt++;
      repeat (2) step();
      if0.req = 4'b0000;
      if0.limit[29:20] = 10'd1023;
      if0.rnd = 10'd999;
      repeat (9) step();
      total++;
      if (if0.ack !== 4'b0100)
         $display("FAIL commit_ack got %b want 0100", if0.ack);
      else pass_cnt++;
      total++;
      if (if0.value !== 10'd4)
         $display("FAIL commit_value got %0d want 4", if0.value);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit seen;
      int n;
      seen = 1'b0;
      if0.req = 4'b1001;
      if0.limit[39:30] = 10'd50;
      if0.rnd = 10'd523;
      step();
      total++;
      if (if0.busy !== 1'b1)
         $display("FAIL mid_latch got %b want 1", if0.busy);
      else pass_cnt++;
      repeat (5) step();
      total++;
      if (if0.value !== 10'd4)
         $display("FAIL mid_value_held got %0d want 4", if0.value);
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total++;
      if ({if0.busy, if0.ack, if0.value} !== 15'd0)
         $display("FAIL mid_async_clear got %0h want 0",
                  {if0.busy, if0.ack, if0.value});
      else pass_cnt++;
      if0.req = 4'b1010;
      if0.limit[19:10] = 10'd99;
      for (int i = 0; i < 15; i++) begin
         step();
         if (if0.ack != 4'b0000) seen = 1'b1;
      end
      total++;
      if (seen)
         $display("FAIL mid_no_ack got %b want 0", seen);
      else pass_cnt++;
      release_rst();
      wait_ack0(ok, n);
      total++;
      if (!ok || if0.ack !== 4'b0010)
         $display("FAIL mid_restart_ack got %b want 0010", if0.ack);
      else pass_cnt++;
      total++;
      if (n != 21 || if0.value !== 10'd23)
         $display("FAIL mid_restart_timing got n=%0d v=%0d want 21/23",
                  n, if0.value);
      else pass_cnt++;
      if0.req = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_first_draw();
      test_limits();
      test_round_robin();
      test_gap20();
      test_commit();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
